// File: rtl/msrv32_dmem_slave_if.sv
//------------------------------------------------------------------------------
// Module   : msrv32_dmem_slave_if
// Purpose  : AHB-lite style data-memory bus between the MSRV32 core (master)
//            and the data-memory slave.
// Signals  : ms_riscv32_mp_dmaddr_in       [31:0] address-phase byte address
//            ms_riscv32_mp_dmdata_in       [31:0] data-phase write data
//            ms_riscv32_mp_dmwr_req_in            1 = write, 0 = read
//            ms_riscv32_mp_dmwr_mask_in    [3:0]  byte-lane enables
//            ms_riscv32_mp_data_htrans_in  [1:0]  transfer type (bit 1 = active)
//            ms_riscv32_mp_data_out        [31:0] read data
//            ms_riscv32_mp_data_hready_out        data phase completes / idle
//            ms_riscv32_mp_hresp_out              1 = ERROR response
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface msrv32_dmem_slave_if;
  logic [31:0] ms_riscv32_mp_dmaddr_in;
  logic [31:0] ms_riscv32_mp_dmdata_in;
  logic        ms_riscv32_mp_dmwr_req_in;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_in;
  logic [1:0]  ms_riscv32_mp_data_htrans_in;
  logic [31:0] ms_riscv32_mp_data_out;
  logic        ms_riscv32_mp_data_hready_out;
  logic        ms_riscv32_mp_hresp_out;

  modport master (
    output ms_riscv32_mp_dmaddr_in,
    output ms_riscv32_mp_dmdata_in,
    output ms_riscv32_mp_dmwr_req_in,
    output ms_riscv32_mp_dmwr_mask_in,
    output ms_riscv32_mp_data_htrans_in,
    input  ms_riscv32_mp_data_out,
    input  ms_riscv32_mp_data_hready_out,
    input  ms_riscv32_mp_hresp_out
  );

  modport slave (
    input  ms_riscv32_mp_dmaddr_in,
    input  ms_riscv32_mp_dmdata_in,
    input  ms_riscv32_mp_dmwr_req_in,
    input  ms_riscv32_mp_dmwr_mask_in,
    input  ms_riscv32_mp_data_htrans_in,
    output ms_riscv32_mp_data_out,
    output ms_riscv32_mp_data_hready_out,
    output ms_riscv32_mp_hresp_out
  );
endinterface

`default_nettype wire

// File: rtl/msrv32_dmem_slave.sv
//------------------------------------------------------------------------------
// Module   : msrv32_dmem_slave
// Purpose  : Word-organised data memory behind an AHB-lite style pipelined
//            bus. Out-of-range transfers get a two-cycle ERROR response.
// Ports    : ms_riscv32_mp_clk_in  clock, rising edge
//            ms_riscv32_mp_rst_in  synchronous active-high reset
//            bus                   msrv32_dmem_slave_if.slave bus signals
// Params   : BASE_ADDR   byte address of word 0
//            DEPTH_WORDS number of 32-bit words (1..65536)
//            WAIT_CYCLES wait states per OKAY transfer (0..15)
// Macro    : MSRV32_DMEM_WAIT_EN - when defined, in-range transfers insert
//            WAIT_CYCLES wait states; otherwise every OKAY data phase
//            completes in its first cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module msrv32_dmem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input wire logic          ms_riscv32_mp_clk_in,
  input wire logic          ms_riscv32_mp_rst_in,
  msrv32_dmem_slave_if.slave bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef MSRV32_DMEM_WAIT_EN
  localparam bit          WAIT_ON   = (WAIT_CYCLES > 0);
`else
  localparam bit          WAIT_ON   = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    WAIT = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [3:0]       mask_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic             hready;
  logic             accept;
  logic             mem_we;
  logic             unused_bits;

  // Offset is taken modulo 2^32 so addresses below BASE_ADDR wrap to large
  // values and fall out of range naturally.
  assign offset   = bus.ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);

  assign hready   = (state == IDLE) || (state == DATA) || (state == ERR2);
  assign accept   = bus.ms_riscv32_mp_data_htrans_in[1] && hready;

  assign bus.ms_riscv32_mp_data_hready_out = hready;
  assign bus.ms_riscv32_mp_hresp_out       = (state == ERR1) || (state == ERR2);
  assign bus.ms_riscv32_mp_data_out        = ((state == DATA) && !wr_q) ? mem[idx_q] : 32'd0;

  // htrans[0] only distinguishes SEQ/NONSEQ and IDLE/BUSY, which this slave
  // treats identically.
  assign unused_bits = bus.ms_riscv32_mp_data_htrans_in[0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DATA, ERR2: begin
        if (accept) begin
          if (!in_range) begin
            state_nxt = ERR1;
          end else if (WAIT_ON) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      mask_q <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q  <= offset[IDX_W+1:2];
        wr_q   <= bus.ms_riscv32_mp_dmwr_req_in;
        mask_q <= bus.ms_riscv32_mp_dmwr_mask_in;
      end
    end
  end

  // The write lands on the edge that ends DATA, so a read in the very next
  // data phase already sees the new bytes. Reset on that edge drops it;
  // contents are never cleared.
  assign mem_we = (state == DATA) && wr_q && !ms_riscv32_mp_rst_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= bus.ms_riscv32_mp_dmdata_in[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/msrv32_dmem_slave.md
MSRV32_DMEM_SLAVE -- requirements
Module: msrv32_dmem_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; legal range 1..65536.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states per OKAY transfer; legal range 0..15; used only under MSRV32_DMEM_WAIT_EN.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
REQ-006 ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
REQ-007 ms_riscv32_mp_dmaddr_in  input  32  address-phase byte address.
REQ-008 ms_riscv32_mp_dmdata_in  input  32  write data, sampled in the data phase.
REQ-009 ms_riscv32_mp_dmwr_req_in  input  1  address-phase direction: 1 = write, 0 = read.
REQ-010 ms_riscv32_mp_dmwr_mask_in  input  4  address-phase byte-lane enables; bit n selects byte n.
REQ-011 ms_riscv32_mp_data_htrans_in  input  2  transfer type; bit 1 set = NONSEQ/SEQ (active).
REQ-012 ms_riscv32_mp_data_out  output  32  read data.
REQ-013 ms_riscv32_mp_data_hready_out  output  1  1 = data phase completes this cycle, or no data phase is pending.
REQ-014 ms_riscv32_mp_hresp_out  output  1  1 = ERROR response.

Function
REQ-015 A transfer SHALL be accepted when htrans_in[1]=1 and hready_out=1; on acceptance the address, direction, mask and range check SHALL be registered for the data phase.
REQ-016 FSM states SHALL be IDLE, DATA, WAIT, ERR1, ERR2.
REQ-017 IDLE: hready=1, hresp=0; an accepted in-range transfer SHALL go to WAIT if WAIT_CYCLES>0, otherwise to DATA; an accepted out-of-range transfer SHALL go to ERR1.
REQ-018 WAIT: hready=0, hresp=0; the counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; at count 0 the FSM SHALL go to DATA.
REQ-019 DATA: hready=1, hresp=0; the transfer completes; a transfer accepted in the same cycle SHALL follow REQ-017; with no accepted transfer the FSM SHALL go to IDLE.
REQ-020 ERR1: hready=0, hresp=1, always followed by ERR2.
REQ-021 ERR2: hready=1, hresp=1; the FSM SHALL accept a new transfer per REQ-017, otherwise go to IDLE.
REQ-022 A transfer SHALL be out of range when (addr - BASE_ADDR), computed as 32-bit unsigned, is >= DEPTH_WORDS*4.
REQ-023 The word index SHALL be (addr - BASE_ADDR)>>2; addr[1:0] SHALL be ignored.
REQ-024 A write SHALL update only mask-enabled bytes from dmdata_in, on the clock edge ending the DATA cycle.
REQ-025 A read SHALL drive the full addressed word on data_out during DATA; data_out SHALL be 0 in all other states, including ERR1/ERR2.
REQ-026 An out-of-range write SHALL NOT modify memory.
REQ-027 A read in the data phase that immediately follows a write to the same word SHALL return the newly written bytes, with no extra latency.
REQ-028 Back-to-back transfers with WAIT_CYCLES=0 SHALL sustain one transfer per cycle.
REQ-029 An htrans value of IDLE (00) or BUSY (01) SHALL NOT start a data phase.

Reset
REQ-030 On reset the FSM SHALL go to IDLE with hready_out=1, hresp_out=0, data_out=0, and the wait counter at 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer and drop any pending write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro MSRV32_DMEM_WAIT_EN defined: each in-range transfer SHALL insert WAIT_CYCLES wait states per REQ-018.
REQ-033 Macro undefined: WAIT SHALL be unreachable, WAIT_CYCLES ignored, and every OKAY data phase SHALL complete in the first cycle.

Verification
REQ-034 Macro off: write 0xDEADBEEF, mask 4'hF, addr 0x10, then read 0x10 back-to-back -> read DATA cycle returns 0xDEADBEEF; hready stays 1 throughout.
REQ-035 Byte lanes: after REQ-034, write 0x11223344 with mask 4'b0101 to 0x10, then read -> 0xDE22BE44.
REQ-036 Out of range: DEPTH_WORDS=1024, write to 0x1000 -> hready 0/1 with hresp 1/1 over two cycles, data_out 0; a following read of word 1023 returns its prior contents.
REQ-037 Macro on, WAIT_CYCLES=2: read of 0x10 -> hready low for exactly 2 cycles, then data returned with hready 1.
REQ-038 Reset during WAIT of a write of 0x55 to 0x20 -> next cycle hready=1, hresp=0, data_out=0; a later read of 0x20 returns its pre-write value.
